// File: rtl/sparse_pair_mac_pkg.sv
// Shared constants and state encoding for the sparse pair multiply-accumulate
// stage that consumes the channel-index matcher output.
package sparse_pair_mac_pkg;

  localparam int W_C_LENGTH = 64;   // weight-channel entries per job (matcher width)
  localparam int POS_W      = 9;    // IA position width
  localparam int VAL_W      = 8;    // signed weight / IA value width
  localparam int ACC_W      = 32;   // signed accumulator width
  localparam int IA_DEPTH   = 256;  // addressable IA values

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sparse_pair_mac_lsb_pick.sv
// Combinational lowest-set-bit encoder over the remaining match mask.
// Kept as its own module so it can be tested alone and retimed if the
// 64-wide priority chain becomes the critical path.
module lsb_pick
  import sparse_pair_mac_pkg::*;
#(
  parameter int N_ENTRIES = W_C_LENGTH
) (
  input  logic [N_ENTRIES-1:0]         mask,
  output logic [$clog2(N_ENTRIES)-1:0] idx,
  output logic                         any
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  assign any = |mask;

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sparse_pair_mac.sv
// Walks the matcher's per-entry match vector one set entry per cycle,
// multiplies weight by the indexed IA value and accumulates a signed dot
// product. One accepted start yields one o_sum with a one-cycle o_done.
module sparse_pair_mac
  import sparse_pair_mac_pkg::*;
#(
  parameter int N_ENTRIES = sparse_pair_mac_pkg::W_C_LENGTH,
  parameter int POS_W     = sparse_pair_mac_pkg::POS_W,
  parameter int IA_DEPTH  = sparse_pair_mac_pkg::IA_DEPTH,
  parameter int VAL_W     = sparse_pair_mac_pkg::VAL_W,
  parameter int ACC_W     = sparse_pair_mac_pkg::ACC_W
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic [N_ENTRIES-1:0]                 i_valid,
  input  logic [N_ENTRIES-1:0][POS_W-1:0]      i_pos,
  input  logic [N_ENTRIES-1:0][VAL_W-1:0]      i_w_val,
  input  logic [IA_DEPTH-1:0][VAL_W-1:0]       i_ia_val,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic signed [ACC_W-1:0]              o_sum,
  output logic [$clog2(N_ENTRIES):0]           o_match_cnt,
  output logic                                 o_oor
);

  localparam int IDX_W  = $clog2(N_ENTRIES);
  localparam int CNT_W  = IDX_W + 1;
  localparam int IA_AW  = $clog2(IA_DEPTH);
  localparam int PROD_W = 2 * VAL_W;
  localparam logic [POS_W:0] IA_LIMIT = (POS_W + 1)'(IA_DEPTH);

  state_e                     state;
  logic [N_ENTRIES-1:0]       mask_r;
  logic [1:0]                 drain_left;

  logic [IDX_W-1:0]           idx_p0;
  logic                       any_p0;
  logic [POS_W-1:0]           pos_p0;
  logic                       oor_p0;
  logic                       issue_p0;
  logic                       start_acc;

  logic signed [VAL_W-1:0]    w_p1;
  logic signed [VAL_W-1:0]    a_p1;
  logic                       vld_p1;
  logic signed [PROD_W-1:0]   prod_p2;
  logic                       vld_p2;
  logic signed [ACC_W-1:0]    acc_r;

  // Two's-complement wrapping accumulate of a sign-extended product.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [PROD_W-1:0] prod
  );
    return acc + ACC_W'(prod);
  endfunction

  lsb_pick #(
    .N_ENTRIES(N_ENTRIES)
  ) u_pick (
    .mask (mask_r),
    .idx  (idx_p0),
    .any  (any_p0)
  );

  // ---- stage 0: pick and address decode ----
  assign pos_p0    = i_pos[idx_p0];
  assign oor_p0    = {1'b0, pos_p0} >= IA_LIMIT;
  assign issue_p0  = (state == ST_SCAN) && any_p0;
  assign start_acc = (state == ST_IDLE) && i_start;

  // Job sequencing: mask walk, drain wait, result publish and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      mask_r      <= '0;
      drain_left  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_sum       <= '0;
      o_match_cnt <= '0;
      o_oor       <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state       <= ST_SCAN;
            mask_r      <= i_valid;
            // An empty job is held to the same latency as a one-match job.
            drain_left  <= (|i_valid) ? 2'd1 : 2'd2;
            o_busy      <= 1'b1;
            o_match_cnt <= '0;
            o_oor       <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (any_p0) begin
            mask_r[idx_p0] <= 1'b0;
            o_match_cnt    <= o_match_cnt + CNT_W'(1);
            if (oor_p0) o_oor <= 1'b1;
          end else begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_left == 2'd0 && !vld_p1 && !vld_p2) begin
            state  <= ST_DONE;
            o_sum  <= acc_r;
            o_done <= 1'b1;
          end else if (drain_left != 2'd0) begin
            drain_left <= drain_left - 2'd1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pipeline valids and the accumulator, cleared by reset and at job start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      acc_r  <= '0;
    end else begin
      vld_p1 <= issue_p0;
      vld_p2 <= vld_p1;
      if (start_acc)   acc_r <= '0;
      else if (vld_p2) acc_r <= acc_add(acc_r, prod_p2);
    end
  end

  // Datapath registers: operand fetch and multiply, qualified by the valids.
  always_ff @(posedge i_clk) begin
    // ---- stage 1: operand fetch ----
    if (issue_p0) begin
      w_p1 <= $signed(i_w_val[idx_p0]);
      a_p1 <= oor_p0 ? '0 : $signed(i_ia_val[pos_p0[IA_AW-1:0]]);
    end
    // ---- stage 2: multiply ----
    if (vld_p1) prod_p2 <= PROD_W'(w_p1) * PROD_W'(a_p1);
  end

endmodule

// File: doc/sparse_pair_mac.md
# sparse_pair_mac

Downstream consumer of the channel-index matcher. Takes the per-weight-entry match vector (valid flag plus 9-bit IA position per weight entry), walks the set entries one per cycle with a priority scan, fetches the weight value and the indexed IA value, multiplies, and accumulates a signed dot product. One `i_start` produces one `o_sum` with a single-cycle `o_done` pulse. The result feeds the partial-sum writeback stage.

## Interface
- N_ENTRIES, 64: weight-channel entries per job; equals the matcher's `W_C_LENGTH`.
- POS_W, 9: width of an IA position.
- IA_DEPTH, 256: number of IA values addressable.
- VAL_W, 8: signed width of weight and IA values.
- ACC_W, 32: signed accumulator width.
- Clock and reset: `i_clk`, with `i_rst_n` asynchronous and active-low.
- i_clk  in  1  clock.
- i_rst_n  in  1  async active-low reset.
- i_start  in  1  job start; sampled only in IDLE.
- i_valid  in  [N_ENTRIES]  match flags from the matcher.
- i_pos  in  N_ENTRIES×POS_W  matched IA position per entry.
- i_w_val  in  N_ENTRIES×VAL_W  signed weight values.
- i_ia_val  in  IA_DEPTH×VAL_W  signed IA values.
- o_busy  out  1  high from the cycle after a start is accepted until `o_done`, inclusive.
- o_done  out  1  one-cycle completion pulse.
- o_sum  out  ACC_W  dot product; held until the next accepted start.
- o_match_cnt  out  $clog2(N_ENTRIES)+1  entries issued this job.
- o_oor  out  1  sticky per job; an issued position was ≥ IA_DEPTH.

## Operation
- States:
  - IDLE: on `i_start`, go to SCAN.
  - SCAN: when the remaining mask is empty, go to DRAIN.
  - DRAIN: after 2 cycles, go to DONE.
  - DONE: after 1 cycle, go to IDLE.
- On an accepted start:
  - latch `i_valid` into `mask_r`;
  - clear `acc_r`, `o_match_cnt` and `o_oor`;
  - `o_sum` keeps its old value until DONE.
- `i_pos`, `i_w_val` and `i_ia_val` are not latched. They must stay stable from start to `o_done`. The matcher's registered outputs guarantee this.
- SCAN, each cycle with `mask_r` non-zero:
  - `idx` = lowest set bit of `mask_r`; clear that bit;
  - stage 1 registers `w = i_w_val[idx]` and `a = i_ia_val[i_pos[idx]]`;
  - increment `o_match_cnt`.
- Out-of-range position (`i_pos[idx] ≥ IA_DEPTH`): the slot is still issued and counted, `a` is forced to 0, and `o_oor` is set.
- Stage 2 registers the product `w*a`, signed, 2·VAL_W bits.
- Stage 3 adds the sign-extended product to `acc_r`. The sum wraps in two's complement; there is no saturation.
- DONE: `o_sum <= acc_r` and `o_done` = 1.
- `i_start` in any state other than IDLE is ignored. No queueing.
- Zero matches (`i_valid` all 0): SCAN lasts one cycle and issues nothing. The result is `o_sum` = 0 and `o_match_cnt` = 0.

## Timing
- Edge 0 samples `i_start`. With M matches, issue edges are 1..M and the last accumulate is at edge M+2.
- `o_done` is high in the cycle after edge max(M,1)+3. Throughput: one match per cycle.
- Pipeline valid bits travel with stages 1 and 2. DRAIN exit requires both to be empty.
- Reset, including mid-job: state IDLE, mask, pipeline and accumulator cleared. Outputs after reset: `o_busy` = 0, `o_done` = 0, `o_sum` = 0, `o_match_cnt` = 0, `o_oor` = 0.
- `o_done` and a new `i_start` in the same cycle: the state is DONE, not IDLE, so the start is ignored. The earliest restart is the cycle after `o_done`.

## Structure
- Shared package `header.h` additions:
  - `W_C_LENGTH`, reused as the N_ENTRIES default;
  - `POS_W`, `VAL_W`, `ACC_W`, `IA_DEPTH`;
  - state encoding constants for IDLE, SCAN, DRAIN, DONE.
- One sub-module, `lsb_pick`: combinational lowest-set-bit encoder over N_ENTRIES. Outputs `idx` and `any`. It is separate so it can be unit-tested and retimed.

## Test plan
- Single match: `i_valid[5]` = 1, `i_pos[5]` = 40, `w[5]` = 3, `ia[40]` = -7 → `o_sum` = -21, `o_match_cnt` = 1, `o_done` at edge 4.
- Full vector: all 64 valid, `i_pos[k]` = k, `w` = 1, `ia[k]` = k → `o_sum` = 2016, `o_match_cnt` = 64, `o_done` at edge 67.
- Zero matches → `o_sum` = 0, `o_match_cnt` = 0, `o_done` at edge 4; the previous `o_sum` is overwritten with 0.
- Out of range: `i_valid[0]` = 1, `i_pos[0]` = 300, `w` = 5 → `o_sum` = 0, `o_oor` = 1, `o_match_cnt` = 1.
- Busy start plus wrap: `i_start` re-pulsed mid-SCAN is ignored, and `o_sum` matches a single job. Separately, 64 products of (-128)(-128) = 16384 each give 1048576, no wrap. A preloaded-accumulator force test checks 0x7FFFFFFF + 1 → 0x80000000.
- Reset mid-job: deassert `i_rst_n` at edge 10 of a 64-match job → all outputs 0 and `o_busy` = 0. A new job afterwards computes correctly.
